// File: rtl/pulse_gap_pkg.sv
// rtl/pulse_gap_pkg.sv - shared FSM state and measurement record for the pulse gap meter
package pulse_gap_pkg;

    localparam int PKG_CNT_W = 8;

    typedef enum logic {
        SEEK    = 1'b0,
        MEASURE = 1'b1
    } gap_state_t;

    typedef struct packed {
        logic [PKG_CNT_W-1:0] period;
        logic [PKG_CNT_W-1:0] width;
        logic                 ovf;
    } meas_rec_t;

endpackage

// File: rtl/pulse_lock_tracker.sv
// rtl/pulse_lock_tracker.sv - counts consecutive identical measurements and flags lock
module pulse_lock_tracker #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             complete,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] width,
    input  logic             ovf,
    output logic             locked
);

    localparam int MW = $clog2(LOCK_COUNT + 1);

    logic [MW-1:0]    match_cnt;
    logic [CNT_W-1:0] prev_period;
    logic [CNT_W-1:0] prev_width;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            match_cnt   <= '0;
            prev_period <= '0;
            prev_width  <= '0;
        end else if (complete) begin
            if (ovf) begin
                match_cnt <= '0;
            end else begin
                // match_cnt of zero means there is no valid previous result to compare with
                if (match_cnt != '0 && period == prev_period && width == prev_width) begin
                    if (match_cnt < MW'(LOCK_COUNT))
                        match_cnt <= match_cnt + 1'b1;
                end else begin
                    match_cnt <= MW'(1);
                end
                prev_period <= period;
                prev_width  <= width;
            end
        end
    end

    assign locked = (match_cnt >= MW'(LOCK_COUNT));

endmodule

// File: rtl/pulse_gap_meter.sv
// rtl/pulse_gap_meter.sv - period/width meter for a serial pulse stream; lock tracker under PULSE_GAP_METER_LOCK_EN
module pulse_gap_meter
    import pulse_gap_pkg::*;
#(
    parameter int CNT_W      = PKG_CNT_W,
    parameter int LOCK_COUNT = 3
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             pulse_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] width_out,
    output logic             ovf_out,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             dropped,
    output logic             locked
);

    typedef struct packed {
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] width;
        logic             ovf;
    } meas_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    gap_state_t       state, state_n;
    logic [CNT_W-1:0] period_cnt, period_n;
    logic [CNT_W-1:0] width_cnt, width_n;
    logic             in_run, in_run_n;
    logic             in_q, rise, complete;
    meas_t            result, held;

    assign rise = pulse_in & ~in_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= SEEK;
            period_cnt <= '0;
            width_cnt  <= '0;
            in_run     <= 1'b0;
            in_q       <= 1'b0;
        end else begin
            state      <= state_n;
            period_cnt <= period_n;
            width_cnt  <= width_n;
            in_run     <= in_run_n;
            in_q       <= pulse_in;
        end
    end

    always_comb begin
        state_n  = state;
        period_n = period_cnt;
        width_n  = width_cnt;
        in_run_n = in_run;
        complete = 1'b0;
        result   = '0;
        if (!enable) begin
            state_n  = SEEK;
            period_n = '0;
            width_n  = '0;
            in_run_n = 1'b0;
        end else begin
            case (state)
                SEEK: begin
                    if (rise) begin
                        state_n  = MEASURE;
                        period_n = CNT_W'(1);
                        width_n  = CNT_W'(1);
                        in_run_n = 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        complete      = 1'b1;
                        result.period = period_cnt;
                        result.width  = width_cnt;
                        period_n      = CNT_W'(1);
                        width_n       = CNT_W'(1);
                        in_run_n      = 1'b1;
                    end else if (period_cnt == CNT_MAX) begin
                        // no closing edge within the counter range: report saturation and re-arm
                        complete      = 1'b1;
                        result.period = CNT_MAX;
                        result.width  = width_cnt;
                        result.ovf    = 1'b1;
                        state_n       = SEEK;
                        period_n      = '0;
                        width_n       = '0;
                        in_run_n      = 1'b0;
                    end else begin
                        period_n = period_cnt + 1'b1;
                        if (in_run && pulse_in && width_cnt != CNT_MAX)
                            width_n = width_cnt + 1'b1;
                        if (!pulse_in)
                            in_run_n = 1'b0;
                    end
                end
                default: state_n = SEEK;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            held       <= '0;
            meas_valid <= 1'b0;
            dropped    <= 1'b0;
        end else if (complete) begin
            if (!meas_valid || meas_ready) begin
                held       <= result;
                meas_valid <= 1'b1;
            end else begin
                dropped <= 1'b1;
            end
        end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
        end
    end

    assign period_out = held.period;
    assign width_out  = held.width;
    assign ovf_out    = held.ovf;

`ifdef PULSE_GAP_METER_LOCK_EN
    pulse_lock_tracker #(
        .CNT_W      (CNT_W),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_lock (
        .clock    (clock),
        .reset_n  (reset_n),
        .complete (complete),
        .period   (result.period),
        .width    (result.width),
        .ovf      (result.ovf),
        .locked   (locked)
    );
`else
    assign locked = 1'b0;
`endif

endmodule

// File: tb/tb_pulse_gap_meter.sv
// tb/tb_pulse_gap_meter.sv - directed self-checking bench for pulse_gap_meter
module tb_pulse_gap_meter;
    import pulse_gap_pkg::*;

    localparam int CNT_W = 8;

`ifdef PULSE_GAP_METER_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset_n, enable, pulse_in, meas_ready;
    logic [CNT_W-1:0] period_out, width_out;
    logic             ovf_out, meas_valid, dropped, locked;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] sr;
    int          q_p[$], q_w[$], q_o[$], q_l[$];

    always #5 clock = ~clock;

    pulse_gap_meter #(.CNT_W(CNT_W), .LOCK_COUNT(3)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .pulse_in   (pulse_in),
        .period_out (period_out),
        .width_out  (width_out),
        .ovf_out    (ovf_out),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .dropped    (dropped),
        .locked     (locked)
    );

    // one clock, then log any result that the consumer takes on the next edge
    task automatic tick();
        @(posedge clock);
        #1;
        if (meas_valid && meas_ready) begin
            q_p.push_back(int'(period_out));
            q_w.push_back(int'(width_out));
            q_o.push_back(int'(ovf_out));
            q_l.push_back(int'(locked));
        end
    endtask

    task automatic drive_sr();
        pulse_in = sr[15];
        sr = {sr[14:0], sr[15]};
    endtask

    task automatic run_sr(input int n);
        for (int i = 0; i < n; i++) begin
            drive_sr();
            tick();
        end
    endtask

    task automatic clear_q();
        q_p.delete(); q_w.delete(); q_o.delete(); q_l.delete();
    endtask

    task automatic idle(input int n);
        enable   = 1'b0;
        pulse_in = 1'b0;
        repeat (n) tick();
        enable = 1'b1;
        clear_q();
    endtask

    task automatic first_latency(output int lat);
        lat = 0;
        do begin
            drive_sr();
            tick();
            lat++;
        end while (!meas_valid && lat < 40);
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b0; pulse_in = 1'b0; meas_ready = 1'b1;
        repeat (3) tick();
        n_vec++; if (period_out !== 8'd0) begin n_err++; $display("FAIL reset_period got %0d want 0", period_out); end
        n_vec++; if (width_out !== 8'd0) begin n_err++; $display("FAIL reset_width got %0d want 0", width_out); end
        n_vec++; if (ovf_out !== 1'b0) begin n_err++; $display("FAIL reset_ovf got %0b want 0", ovf_out); end
        n_vec++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got %0b want 0", meas_valid); end
        n_vec++; if (dropped !== 1'b0) begin n_err++; $display("FAIL reset_dropped got %0b want 0", dropped); end
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL reset_locked got %0b want 0", locked); end
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();
        n_vec++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_valid got %0b want 0", meas_valid); end
    endtask

    task automatic test_period8();
        int lat;
        clear_q();
        sr = 16'h8080;
        first_latency(lat);
        n_vec++; if (lat !== 9) begin n_err++; $display("FAIL p8_latency got %0d want 9", lat); end
        run_sr(40);
        n_vec++; if (q_p.size() !== 6) begin n_err++; $display("FAIL p8_count got %0d want 6", q_p.size()); end
        for (int i = 0; i < q_p.size() && i < 6; i++) begin
            n_vec++; if (q_p[i] !== 8) begin n_err++; $display("FAIL p8_period[%0d] got %0d want 8", i, q_p[i]); end
            n_vec++; if (q_w[i] !== 1) begin n_err++; $display("FAIL p8_width[%0d] got %0d want 1", i, q_w[i]); end
            n_vec++; if (q_o[i] !== 0) begin n_err++; $display("FAIL p8_ovf[%0d] got %0d want 0", i, q_o[i]); end
            n_vec++; if (q_l[i] !== int'(LOCK_ON && i >= 2)) begin n_err++; $display("FAIL p8_locked[%0d] got %0d want %0d", i, q_l[i], int'(LOCK_ON && i >= 2)); end
        end
    endtask

    task automatic test_switch();
        int exp_p[8] = '{16, 16, 16, 16, 16, 8, 8, 8};
        int exp_w[8] = '{2, 2, 2, 2, 2, 1, 1, 1};
        int exp_l[8] = '{0, 0, 1, 1, 1, 0, 0, 1};
        idle(3);
        sr = 16'hC000;
        run_sr(80);
        sr = 16'h8080;
        run_sr(32);
        n_vec++; if (q_p.size() !== 8) begin n_err++; $display("FAIL sw_count got %0d want 8", q_p.size()); end
        for (int i = 0; i < q_p.size() && i < 8; i++) begin
            n_vec++; if (q_p[i] !== exp_p[i]) begin n_err++; $display("FAIL sw_period[%0d] got %0d want %0d", i, q_p[i], exp_p[i]); end
            n_vec++; if (q_w[i] !== exp_w[i]) begin n_err++; $display("FAIL sw_width[%0d] got %0d want %0d", i, q_w[i], exp_w[i]); end
            n_vec++; if (q_l[i] !== (LOCK_ON ? exp_l[i] : 0)) begin n_err++; $display("FAIL sw_locked[%0d] got %0d want %0d", i, q_l[i], LOCK_ON ? exp_l[i] : 0); end
        end
    endtask

    task automatic test_overflow();
        idle(3);
        pulse_in = 1'b1;
        tick();
        pulse_in = 1'b0;
        repeat (300) tick();
        n_vec++; if (q_p.size() !== 1) begin n_err++; $display("FAIL ovf_count got %0d want 1", q_p.size()); end
        if (q_p.size() > 0) begin
            n_vec++; if (q_p[0] !== 255) begin n_err++; $display("FAIL ovf_period got %0d want 255", q_p[0]); end
            n_vec++; if (q_w[0] !== 1) begin n_err++; $display("FAIL ovf_width got %0d want 1", q_w[0]); end
            n_vec++; if (q_o[0] !== 1) begin n_err++; $display("FAIL ovf_flag got %0d want 1", q_o[0]); end
            n_vec++; if (q_l[0] !== 0) begin n_err++; $display("FAIL ovf_locked got %0d want 0", q_l[0]); end
        end
        n_vec++; if (dut.state !== SEEK) begin n_err++; $display("FAIL ovf_state got %0d want %0d", dut.state, SEEK); end
    endtask

    task automatic test_const_high();
        idle(3);
        pulse_in = 1'b1;
        repeat (300) tick();
        n_vec++; if (q_p.size() !== 1) begin n_err++; $display("FAIL high_count got %0d want 1", q_p.size()); end
        if (q_p.size() > 0) begin
            n_vec++; if (q_p[0] !== 255) begin n_err++; $display("FAIL high_period got %0d want 255", q_p[0]); end
            n_vec++; if (q_w[0] !== 255) begin n_err++; $display("FAIL high_width got %0d want 255", q_w[0]); end
            n_vec++; if (q_o[0] !== 1) begin n_err++; $display("FAIL high_ovf got %0d want 1", q_o[0]); end
        end
    endtask

    task automatic test_dropped();
        idle(3);
        meas_ready = 1'b0;
        sr = 16'h8080;
        run_sr(9);
        n_vec++; if (meas_valid !== 1'b1) begin n_err++; $display("FAIL drop_first_valid got %0b want 1", meas_valid); end
        n_vec++; if (dropped !== 1'b0) begin n_err++; $display("FAIL drop_early got %0b want 0", dropped); end
        run_sr(11);
        n_vec++; if (meas_valid !== 1'b1) begin n_err++; $display("FAIL drop_held_valid got %0b want 1", meas_valid); end
        n_vec++; if (period_out !== 8'd8) begin n_err++; $display("FAIL drop_held_period got %0d want 8", period_out); end
        n_vec++; if (width_out !== 8'd1) begin n_err++; $display("FAIL drop_held_width got %0d want 1", width_out); end
        n_vec++; if (dropped !== 1'b1) begin n_err++; $display("FAIL drop_flag got %0b want 1", dropped); end
        meas_ready = 1'b1;
        run_sr(1);
        n_vec++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL drop_handshake_valid got %0b want 0", meas_valid); end
        clear_q();
        run_sr(8);
        n_vec++; if (q_p.size() !== 1) begin n_err++; $display("FAIL drop_next_count got %0d want 1", q_p.size()); end
        if (q_p.size() > 0) begin
            n_vec++; if (q_p[0] !== 8 || q_w[0] !== 1) begin n_err++; $display("FAIL drop_next_result got %0d/%0d want 8/1", q_p[0], q_w[0]); end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int guard = 0;
        clear_q();
        while (q_p.size() == 0 && guard < 20) begin
            run_sr(1);
            guard++;
        end
        run_sr(3);
        reset_n = 1'b0;
        #1;
        n_vec++; if (period_out !== 8'd0) begin n_err++; $display("FAIL rmid_period got %0d want 0", period_out); end
        n_vec++; if (width_out !== 8'd0) begin n_err++; $display("FAIL rmid_width got %0d want 0", width_out); end
        n_vec++; if (meas_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid got %0b want 0", meas_valid); end
        n_vec++; if (dropped !== 1'b0) begin n_err++; $display("FAIL rmid_dropped got %0b want 0", dropped); end
        n_vec++; if (locked !== 1'b0) begin n_err++; $display("FAIL rmid_locked got %0b want 0", locked); end
        pulse_in = 1'b0;
        repeat (2) tick();
        reset_n = 1'b1;
        sr = 16'h8080;
        first_latency(lat);
        n_vec++; if (lat !== 9) begin n_err++; $display("FAIL rmid_latency got %0d want 9", lat); end
        n_vec++; if (period_out !== 8'd8) begin n_err++; $display("FAIL rmid_first_period got %0d want 8", period_out); end
    endtask

    task automatic test_enable_gap();
        int highs = 0;
        run_sr(2);
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive_sr();
            tick();
            if (meas_valid) highs++;
        end
        n_vec++; if (highs !== 0) begin n_err++; $display("FAIL gap_valid_cycles got %0d want 0", highs); end
        enable = 1'b1;
        clear_q();
        run_sr(16);
        n_vec++; if (q_p.size() !== 1) begin n_err++; $display("FAIL gap_count got %0d want 1", q_p.size()); end
        if (q_p.size() > 0) begin
            n_vec++; if (q_p[0] !== 8) begin n_err++; $display("FAIL gap_period got %0d want 8", q_p[0]); end
            n_vec++; if (q_w[0] !== 1) begin n_err++; $display("FAIL gap_width got %0d want 1", q_w[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_period8();
        test_switch();
        test_overflow();
        test_const_high();
        test_dropped();
        test_reset_mid();
        test_enable_gap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
